// File: rtl/rename_map_ckpt.sv
// Register-rename map table (32 architectural entries) with a circular FIFO of full-table
// checkpoints for branch recovery. Define MAPTABLE_BYPASS_EN to forward same-cycle writes to reads.
module rename_map_ckpt #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned NREAD  = 8,
  parameter int unsigned NWRITE = 4,
  parameter int unsigned NCKPT  = 4,
  localparam int unsigned CW    = $clog2(NCKPT)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREAD*5-1:0]      i_raddr,
  output logic [NREAD*WIDTH-1:0]  o_rdata,
  input  logic [NWRITE-1:0]       i_we,
  input  logic [NWRITE*5-1:0]     i_waddr,
  input  logic [NWRITE*WIDTH-1:0] i_wdata,
  input  logic                    i_ckpt_req,
  output logic [CW-1:0]           o_ckpt_id,
  output logic                    o_ckpt_full,
  output logic [CW:0]             o_ckpt_cnt,
  input  logic                    i_restore,
  input  logic [CW-1:0]           i_restore_id,
  input  logic                    i_release
);

  logic [WIDTH-1:0] table_q  [32];
  logic [WIDTH-1:0] table_d  [32];
  logic [WIDTH-1:0] table_wr [32];
  logic [WIDTH-1:0] snap_q   [NCKPT][32];

  logic [CW:0]   head_q, head_d, tail_q, tail_d, cnt;
  logic [CW-1:0] restore_off;
  logic          full, restore_live, take, rel;

  assign cnt  = tail_q - head_q;
  assign full = (tail_q[CW-1:0] == head_q[CW-1:0]) && (tail_q[CW] != head_q[CW]);

  // An id is live when its distance from head is below the live count.
  assign restore_off  = i_restore_id - head_q[CW-1:0];
  assign restore_live = i_restore && ({1'b0, restore_off} < cnt);
  assign take         = i_ckpt_req && !full && !restore_live;
  assign rel          = i_release && (cnt != '0) && !restore_live;

  // Ascending port order lets the highest-indexed port win on a collision.
  always_comb begin
    table_wr = table_q;
    for (int unsigned j = 0; j < NWRITE; j++) begin
      if (i_we[j] && (i_waddr[5*j +: 5] != 5'd0)) begin
        table_wr[i_waddr[5*j +: 5]] = i_wdata[WIDTH*j +: WIDTH];
      end
    end
  end

  always_comb begin
    if (restore_live) begin
      table_d = snap_q[i_restore_id];
    end else begin
      table_d = table_wr;
    end
    head_d = head_q;
    if (rel) begin
      head_d = head_q + 1'b1;
    end
    tail_d = tail_q;
    if (restore_live) begin
      tail_d = head_q + {1'b0, restore_off};
    end else if (take) begin
      tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned e = 0; e < 32; e++) begin
        table_q[e] <= '0;
        for (int unsigned s = 0; s < NCKPT; s++) begin
          snap_q[s][e] <= '0;
        end
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      table_q <= table_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (take) begin
        snap_q[tail_q[CW-1:0]] <= table_wr;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      if (i_raddr[5*k +: 5] != 5'd0) begin
        o_rdata[WIDTH*k +: WIDTH] = table_q[i_raddr[5*k +: 5]];
      end
`ifdef MAPTABLE_BYPASS_EN
      for (int unsigned j = 0; j < NWRITE; j++) begin
        if (!restore_live && i_we[j] && (i_waddr[5*j +: 5] == i_raddr[5*k +: 5]) &&
            (i_waddr[5*j +: 5] != 5'd0)) begin
          o_rdata[WIDTH*k +: WIDTH] = i_wdata[WIDTH*j +: WIDTH];
        end
      end
`endif
    end
  end

  assign o_ckpt_id   = tail_q[CW-1:0];
  assign o_ckpt_full = full;
  assign o_ckpt_cnt  = cnt;

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Randomized scoreboard bench for rename_map_ckpt against a queue-based checkpoint model.
module tb_rename_map_ckpt;
  localparam int W  = 6;
  localparam int NR = 8;
  localparam int NW = 4;
  localparam int NC = 4;
  localparam int CW = 2;

  logic              clk, rst_n;
  logic [NR*5-1:0]   raddr;
  logic [NR*W-1:0]   rdata;
  logic [NW-1:0]     we;
  logic [NW*5-1:0]   waddr;
  logic [NW*W-1:0]   wdata;
  logic              ckpt_req, restore, release_r;
  logic [CW-1:0]     restore_id, ckpt_id;
  logic              ckpt_full;
  logic [CW:0]       ckpt_cnt;

  rename_map_ckpt #(.WIDTH(W), .NREAD(NR), .NWRITE(NW), .NCKPT(NC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata), .i_we(we),
    .i_waddr(waddr), .i_wdata(wdata), .i_ckpt_req(ckpt_req), .o_ckpt_id(ckpt_id),
    .o_ckpt_full(ckpt_full), .o_ckpt_cnt(ckpt_cnt), .i_restore(restore),
    .i_restore_id(restore_id), .i_release(release_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR*W-1:0] rdata;
    logic [CW:0]     cnt;
    logic            full;
    logic [CW-1:0]   id;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: live checkpoints are a queue of (slot id, table image), oldest first.
  logic [W-1:0]      m_tbl [32];
  int                m_head;
  int                m_sid [$];
  logic [32*W-1:0]   m_snap[$];

  function automatic logic [32*W-1:0] pack_tbl();
    logic [32*W-1:0] v;
    for (int e = 0; e < 32; e++) v[W*e +: W] = m_tbl[e];
    return v;
  endfunction

  function automatic int find_live(int id);
    for (int i = 0; i < m_sid.size(); i++) if (m_sid[i] == id) return i;
    return -1;
  endfunction

  function automatic logic [NW*5-1:0] wa4(int a0, int a1, int a2, int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [NW*W-1:0] wd4(int d0, int d1, int d2, int d3);
    return {W'(d3), W'(d2), W'(d1), W'(d0)};
  endfunction

  function automatic logic [NR*5-1:0] ra8(int base);
    logic [NR*5-1:0] v;
    for (int k = 0; k < NR; k++) v[5*k +: 5] = 5'((base + k) % 32);
    return v;
  endfunction

  task automatic model_clear();
    for (int e = 0; e < 32; e++) m_tbl[e] = '0;
    m_head = 0;
    m_sid.delete();
    m_snap.delete();
  endtask

  task automatic step(input logic [NW-1:0] s_we, input logic [NW*5-1:0] s_wa,
                      input logic [NW*W-1:0] s_wd, input logic [NR*5-1:0] s_ra,
                      input logic s_ck, input logic s_rel, input logic s_rs,
                      input logic [CW-1:0] s_rid);
    exp_t e;
    int p, n0;
    logic [4:0] a;
    logic [W-1:0] v;
    logic [32*W-1:0] img;
    @(negedge clk);
    we = s_we; waddr = s_wa; wdata = s_wd; raddr = s_ra;
    ckpt_req = s_ck; release_r = s_rel; restore = s_rs; restore_id = s_rid;
    p = s_rs ? find_live(int'(s_rid)) : -1;
    for (int k = 0; k < NR; k++) begin
      a = s_ra[5*k +: 5];
      v = (a == 5'd0) ? '0 : m_tbl[a];
`ifdef MAPTABLE_BYPASS_EN
      if (p < 0) begin
        for (int j = 0; j < NW; j++)
          if (s_we[j] && s_wa[5*j +: 5] == a && a != 5'd0) v = s_wd[W*j +: W];
      end
`endif
      e.rdata[W*k +: W] = v;
    end
    n0 = m_sid.size();
    e.cnt  = (CW+1)'(n0);
    e.full = (n0 == NC);
    e.id   = CW'((m_head + n0) % NC);
    exp_q.push_back(e);
    @(posedge clk);
    if (p >= 0) begin
      img = m_snap[p];
      for (int i = 0; i < 32; i++) m_tbl[i] = img[W*i +: W];
      while (m_sid.size() > p) begin
        void'(m_sid.pop_back());
        void'(m_snap.pop_back());
      end
    end else begin
      for (int j = 0; j < NW; j++)
        if (s_we[j] && s_wa[5*j +: 5] != 5'd0) m_tbl[s_wa[5*j +: 5]] = s_wd[W*j +: W];
      if (s_ck && n0 < NC) begin
        m_sid.push_back((m_head + n0) % NC);
        m_snap.push_back(pack_tbl());
      end
      if (s_rel && n0 > 0) begin
        void'(m_sid.pop_front());
        void'(m_snap.pop_front());
        m_head = (m_head + 1) % NC;
      end
    end
  endtask

  task automatic idle(input int base);
    step('0, '0, '0, ra8(base), 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    we = '0; ckpt_req = 1'b0; release_r = 1'b0; restore = 1'b0; restore_id = '0;
    raddr = {$urandom, $urandom};
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  // Monitor: compares every issued expectation once inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (rdata !== e.rdata) begin
          bad++; $display("FAIL rdata: got %h expected %h (raddr %h)", rdata, e.rdata, raddr);
        end
        total++;
        if (ckpt_cnt !== e.cnt) begin
          bad++; $display("FAIL ckpt_cnt: got %0d expected %0d", ckpt_cnt, e.cnt);
        end
        total++;
        if (ckpt_full !== e.full) begin
          bad++; $display("FAIL ckpt_full: got %0b expected %0b", ckpt_full, e.full);
        end
        total++;
        if (ckpt_id !== e.id) begin
          bad++; $display("FAIL ckpt_id: got %0d expected %0d", ckpt_id, e.id);
        end
      end
    end
  end

  initial begin
    logic [NW-1:0]   r_we;
    logic [NW*5-1:0] r_wa;
    logic [NR*5-1:0] r_ra;
    rst_n = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0;
    ckpt_req = 1'b0; release_r = 1'b0; restore = 1'b0; restore_id = '0;
    model_clear();

    do_reset();
    for (int b = 0; b < 32; b += 8) idle(b);

    step(4'b1001, wa4(5, 0, 0, 5), wd4('h11, 0, 0, 'h2A), ra8(0), 1'b0, 1'b0, 1'b0, '0);
    step(4'b0001, wa4(0, 0, 0, 0), wd4('h3F, 0, 0, 0), ra8(0), 1'b0, 1'b0, 1'b0, '0);
    idle(0);

    do_reset();
    step(4'b0001, wa4(1, 0, 0, 0), wd4('h07, 0, 0, 0), ra8(0), 1'b1, 1'b0, 1'b0, '0);
    step(4'b0001, wa4(1, 0, 0, 0), wd4('h09, 0, 0, 0), ra8(0), 1'b0, 1'b0, 1'b0, '0);
    step('0, '0, '0, ra8(0), 1'b0, 1'b0, 1'b1, 2'd0);
    idle(0);
    idle(0);

    do_reset();
    repeat (5) step('0, '0, '0, ra8(0), 1'b1, 1'b0, 1'b0, '0);
    step('0, '0, '0, ra8(0), 1'b0, 1'b1, 1'b0, '0);
    step('0, '0, '0, ra8(0), 1'b1, 1'b0, 1'b0, '0);
    idle(0);
    step('0, '0, '0, ra8(0), 1'b1, 1'b1, 1'b0, '0);
    idle(0);

    do_reset();
    step('0, '0, '0, ra8(0), 1'b1, 1'b0, 1'b0, '0);
    step(4'b0001, wa4(3, 0, 0, 0), wd4('h15, 0, 0, 0), ra8(0), 1'b0, 1'b0, 1'b1, 2'd2);
    idle(0);

    do_reset();
    step(4'b0001, wa4(4, 0, 0, 0), wd4('h33, 0, 0, 0), ra8(0), 1'b0, 1'b0, 1'b0, '0);
    idle(0);

    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      r_we = NW'($urandom);
      for (int j = 0; j < NW; j++)
        r_wa[5*j +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      for (int k = 0; k < NR; k++)
        r_ra[5*k +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      step(r_we, r_wa, NW*W'({$urandom}), r_ra, ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), CW'($urandom));
    end

    repeat (3) @(negedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
